cim_gemm_sequencer: RTL and testbench

Command-driven sequencer for the Basic_GeMM_CIM macro, sitting between the darkriscv-side control and the macro's strobe interface.
- Accepts one command at a time: weight load, or compute.
- Streams weight rows or activation words from a valid/ready source into the macro.
- Computes issue `reset_output`, then accumulate with `partial_sum`; the sequencer then drains the selected output registers to a valid/ready result stream.
- Replaces CPU bit-banging of `write`, `cim`, `partial_sum`, `reset_output` and `output_reg`.

---
 rtl/cim_gemm_sequencer_if.sv | 52 +++++
 rtl/cim_gemm_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_cim_gemm_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cim_gemm_sequencer_if.sv
// Command, stream and macro-strobe bundle for cim_gemm_sequencer; slave = sequencer side.
// Optional perf_cycles appears when CIM_SEQ_PERF_CNT_EN is defined.
interface cim_gemm_sequencer_if #(
  parameter int KW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [31:0]   cmd_addr;
  logic [KW-1:0] cmd_len;
  logic [3:0]    cmd_nout;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          busy;
  logic          done;
  logic          cs;
  logic          write;
  logic          cim;
  logic          partial_sum;
  logic          reset_output;
  logic [3:0]    output_reg;
  logic [31:0]   address;
  logic [31:0]   input_data;
  logic [31:0]   cim_output;
`ifdef CIM_SEQ_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  modport slave (
`ifdef CIM_SEQ_PERF_CNT_EN
    output perf_cycles,
`endif
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_nout,
    input  in_valid, in_data, out_ready, cim_output,
    output cmd_ready, in_ready, out_valid, out_data, busy, done, cs,
    output write, cim, partial_sum, reset_output, output_reg, address, input_data
  );

  modport master (
`ifdef CIM_SEQ_PERF_CNT_EN
    input  perf_cycles,
`endif
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_nout,
    output in_valid, in_data, out_ready, cim_output,
    input  cmd_ready, in_ready, out_valid, out_data, busy, done, cs,
    input  write, cim, partial_sum, reset_output, output_reg, address, input_data
  );
endinterface

// File: rtl/cim_gemm_sequencer.sv
// Command sequencer for the GeMM CIM macro: weight load / compute with result drain; all outputs registered.
// Stalls on in_valid low and out_ready low; CIM_SEQ_PERF_CNT_EN adds the perf_cycles accept-to-done counter.
module cim_gemm_sequencer #(
  parameter int KW         = 8,
  parameter int SETTLE_CYC = 2,
  parameter int RD_LAT     = 1
) (
  input logic                 CLK,
  input logic                 RES,
  cim_gemm_sequencer_if.slave bus
);

  localparam int CNT_MAX = (SETTLE_CYC > RD_LAT) ? SETTLE_CYC : RD_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_COMPUTE, S_SETTLE, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [KW-1:0] len_q, len_d;
  logic [KW-1:0] idx_q, idx_d;
  logic [3:0]    nout_q, nout_d;
  logic [3:0]    r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          cmd_ready_q, cmd_ready_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          write_q, write_d;
  logic          cim_q, cim_d;
  logic          partial_sum_q, partial_sum_d;
  logic          reset_output_q, reset_output_d;
  logic [3:0]    output_reg_q, output_reg_d;
  logic [31:0]   address_q, address_d;
  logic [31:0]   input_data_q, input_data_d;
`ifdef CIM_SEQ_PERF_CNT_EN
  logic [31:0]   perf_q, perf_d;
`endif

  logic accept;
  logic beat;

  assign accept = bus.cmd_valid && cmd_ready_q;
  assign beat   = bus.in_valid && in_ready_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    idx_d          = idx_q;
    nout_d         = nout_q;
    r_d            = r_q;
    cnt_d          = cnt_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    done_d         = 1'b0;
    write_d        = 1'b0;
    cim_d          = 1'b0;
    partial_sum_d  = 1'b0;
    reset_output_d = 1'b0;
    output_reg_d   = output_reg_q;
    address_d      = address_q;
    input_data_d   = input_data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = bus.cmd_addr;
          len_d  = bus.cmd_len;
          nout_d = bus.cmd_nout;
          idx_d  = '0;
          r_d    = '0;
          if (bus.cmd_len == '0) begin
            done_d = 1'b1;
          end else if (bus.cmd_op) begin
            state_d        = S_CLEAR;
            reset_output_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD, S_COMPUTE: begin
        if (beat) begin
          address_d    = addr_q + 32'(idx_q);
          input_data_d = bus.in_data;
          idx_d        = idx_q + KW'(1);
          if (state_q == S_LOAD) begin
            write_d = 1'b1;
          end else begin
            cim_d         = 1'b1;
            partial_sum_d = (idx_q != '0);
          end
          if (idx_q == len_q - KW'(1)) begin
            if (state_q == S_LOAD) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_SETTLE;
              cnt_d   = '0;
            end
          end
        end
      end
      S_CLEAR: begin
        state_d = S_COMPUTE;
      end
      // The first SETTLE cycle carries the final cim strobe, hence SETTLE_CYC+1 cycles here.
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYC)) begin
          state_d      = S_DRAIN;
          cnt_d        = '0;
          output_reg_d = r_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (!out_valid_q) begin
          if (cnt_q == CW'(RD_LAT - 1)) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.cim_output;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          if (r_q == nout_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            r_d          = r_q + 4'd1;
            output_reg_d = r_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
    in_ready_d  = (state_d == S_LOAD) || (state_d == S_COMPUTE);
  end

`ifdef CIM_SEQ_PERF_CNT_EN
  // Counts the accept cycle plus every busy cycle, so the value at done equals accept-to-done distance.
  always_comb begin
    perf_d = perf_q;
    if (accept) begin
      perf_d = 32'd1;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RES) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      nout_q         <= '0;
      r_q            <= '0;
      cnt_q          <= '0;
      cmd_ready_q    <= 1'b1;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      write_q        <= 1'b0;
      cim_q          <= 1'b0;
      partial_sum_q  <= 1'b0;
      reset_output_q <= 1'b0;
      output_reg_q   <= '0;
      address_q      <= '0;
      input_data_q   <= '0;
`ifdef CIM_SEQ_PERF_CNT_EN
      perf_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      nout_q         <= nout_d;
      r_q            <= r_d;
      cnt_q          <= cnt_d;
      cmd_ready_q    <= cmd_ready_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      write_q        <= write_d;
      cim_q          <= cim_d;
      partial_sum_q  <= partial_sum_d;
      reset_output_q <= reset_output_d;
      output_reg_q   <= output_reg_d;
      address_q      <= address_d;
      input_data_q   <= input_data_d;
`ifdef CIM_SEQ_PERF_CNT_EN
      perf_q         <= perf_d;
`endif
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.busy         = busy_q;
  assign bus.cs           = busy_q;
  assign bus.done         = done_q;
  assign bus.write        = write_q;
  assign bus.cim          = cim_q;
  assign bus.partial_sum  = partial_sum_q;
  assign bus.reset_output = reset_output_q;
  assign bus.output_reg   = output_reg_q;
  assign bus.address      = address_q;
  assign bus.input_data   = input_data_q;
`ifdef CIM_SEQ_PERF_CNT_EN
  assign bus.perf_cycles  = perf_q;
`endif

endmodule

// File: tb/tb_cim_gemm_sequencer.sv
// Directed per-cycle vector table for cim_gemm_sequencer plus hand-written reset-abort and re-run sequence.
module tb_cim_gemm_sequencer;

  logic clk;
  logic res;

  cim_gemm_sequencer_if #(.KW(8)) bus ();

  cim_gemm_sequencer #(.KW(8), .SETTLE_CYC(2), .RD_LAT(1)) dut (
    .CLK (clk),
    .RES (res),
    .bus (bus)
  );

  // Macro read model: register n reads back as 0xC0DE000n.
  assign bus.cim_output = {16'hC0DE, 12'h000, bus.output_reg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic        op;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  nout;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic [9:0]  ctl;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [31:0] eo;
    logic [3:0]  er;
  } vec_t;

  vec_t tv[$];
  int   nchk;
  int   nerr;

  function automatic vec_t mk(logic cv, logic op, logic [31:0] addr, logic [7:0] len, logic [3:0] nout,
                              logic iv, logic [31:0] id, logic ordy, logic [9:0] ctl,
                              logic [31:0] ea, logic [31:0] ed, logic [31:0] eo, logic [3:0] er);
    vec_t v;
    v.cv = cv; v.op = op; v.addr = addr; v.len = len; v.nout = nout;
    v.iv = iv; v.id = id; v.ordy = ordy;
    v.ctl = ctl; v.ea = ea; v.ed = ed; v.eo = eo; v.er = er;
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bit order: cmd_ready in_ready write cim partial_sum reset_output done busy cs out_valid
  function automatic logic [9:0] ctl_now();
    return {bus.cmd_ready, bus.in_ready, bus.write, bus.cim, bus.partial_sum,
            bus.reset_output, bus.done, bus.busy, bus.cs, bus.out_valid};
  endfunction

  task automatic drive(input vec_t v);
    bus.cmd_valid = v.cv;
    bus.cmd_op    = v.op;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.cmd_nout  = v.nout;
    bus.in_valid  = v.iv;
    bus.in_data   = v.id;
    bus.out_ready = v.ordy;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    logic got;
    int   at;
    int   ncim;
    int   nps;

    nchk = 0;
    nerr = 0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Test 1: load 3 words at 0x10, no stalls; compute accepted in the done cycle.
    tv.push_back(mk(1, 0, 'h10, 3, 0, 0, 0,      0, 10'b1000000000, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'hA,   0, 10'b0100000110, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'hB,   0, 10'b0110000110, 'h10, 'hA, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'hC,   0, 10'b0110000110, 'h11, 'hB, 0, 0));
    tv.push_back(mk(1, 1, 0, 4, 1,     0, 0,     0, 10'b1010001000, 'h12, 'hC, 0, 0));
    // Test 2/3: CLEAR, 4 beats with a stall, settle, drain regs 0..1 with backpressure on reg 1.
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'h100, 0, 10'b0000010110, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'h100, 0, 10'b0100000110, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     0, 10'b0101000110, 0, 'h100, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'h101, 0, 10'b0100000110, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'h102, 0, 10'b0101100110, 1, 'h101, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'h103, 0, 10'b0101100110, 2, 'h102, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'hBAD, 0, 10'b0001100110, 3, 'h103, 0, 0));
    tv.push_back(mk(1, 0, 'h77, 5, 0,  0, 0,     0, 10'b0000000110, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     0, 10'b0000000110, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 10'b0000000110, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 10'b0000000111, 0, 0, 'hC0DE0000, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     0, 10'b0000000110, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      tv.push_back(mk(0, 0, 0, 0, 0,   0, 0,     0, 10'b0000000111, 0, 0, 'hC0DE0001, 1));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     1, 10'b0000000111, 0, 0, 'hC0DE0001, 1));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     0, 10'b1000001000, 0, 0, 0, 0));
    // Test 4: zero-length compute.
    tv.push_back(mk(1, 1, 'h55, 0, 0,  0, 0,     0, 10'b1000000000, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     0, 10'b1000001000, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     0, 10'b1000000000, 0, 0, 0, 0));
    // Test 6: address wrap.
    tv.push_back(mk(1, 0, 'hFFFFFFFF, 2, 0, 0, 0, 0, 10'b1000000000, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'h11,  0, 10'b0100000110, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     1, 'h22,  0, 10'b0110000110, 'hFFFFFFFF, 'h11, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     0, 10'b1010001000, 0, 'h22, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0,     0, 0,     0, 10'b1000000000, 0, 0, 0, 0));

    res = 1'b0;
    drive(idle);
    repeat (3) @(negedge clk);
    check("reset_ctl", ctl_now(), 10'b1000000000);
    check("reset_data", {bus.address, bus.input_data, bus.out_data, bus.output_reg}, 100'h0);
    res = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      check($sformatf("row%0d_ctl", i), ctl_now(), tv[i].ctl);
      if (tv[i].ctl[7] || tv[i].ctl[6])
        check($sformatf("row%0d_addr_data", i), {bus.address, bus.input_data}, {tv[i].ea, tv[i].ed});
      if (tv[i].ctl[0])
        check($sformatf("row%0d_result", i), {bus.out_data, bus.output_reg}, {tv[i].eo, tv[i].er});
      drive(tv[i]);
    end
`ifdef CIM_SEQ_PERF_CNT_EN
    check("perf_wrap_load", bus.perf_cycles, 32'd3);
`endif

    // Test 5: reset after 2 of 4 compute beats.
    @(negedge clk);
    drive(mk(1, 1, 'h40, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 1, 'h1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    bus.in_data = 'h2;
    @(negedge clk);
    check("abort_pre_cim", ctl_now(), 10'b0101100110);
    bus.in_valid = 1'b0;
    res = 1'b0;
    @(negedge clk);
    res = 1'b1;
    check("abort_ctl", ctl_now(), 10'b1000000000);
    check("abort_data", {bus.address, bus.input_data, bus.out_data, bus.output_reg}, 100'h0);
`ifdef CIM_SEQ_PERF_CNT_EN
    check("abort_perf", bus.perf_cycles, 32'd0);
`endif
    @(negedge clk);
    check("abort_no_done", ctl_now(), 10'b1000000000);

    // Follow-up len=1 compute after the abort.
    drive(mk(1, 1, 'h80, 1, 0, 1, 'h77, 1, 0, 0, 0, 0, 0));
    got  = 1'b0;
    at   = -1;
    ncim = 0;
    nps  = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.cim) begin
        ncim++;
        if (bus.partial_sum) nps++;
        check("rerun_cim_addr", {bus.address, bus.input_data}, {32'h80, 32'h77});
      end
      if (bus.out_valid) begin
        got = 1'b1;
        at  = i;
      end
    end
    check("rerun_valid_seen", got, 1'b1);
    check("rerun_latency", at, 6);
    check("rerun_cim_count", {ncim[7:0], nps[7:0]}, 16'h0100);
    check("rerun_result", {bus.out_data, bus.output_reg}, {32'hC0DE0000, 4'h0});
    @(negedge clk);
    check("rerun_done", ctl_now(), 10'b1000001000);
`ifdef CIM_SEQ_PERF_CNT_EN
    check("rerun_perf", bus.perf_cycles, 32'd8);
`endif
    drive(idle);
    @(negedge clk);
    check("rerun_idle", ctl_now(), 10'b1000000000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
